// File: rtl/stack_game_sequencer.sv
// Block-stacking game sequencer: bounces the active row's block, locks and trims it on stop, and flags win/lose.
// Latency: a lock commits on the 3rd clk edge after stop_btn rises; all outputs are registered; no backpressure, ticks and presses are never stalled.
module stack_game_sequencer #(
  parameter int START_WIDTH   = 3,
  parameter int HOLDOFF_TICKS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_sw,
  input  logic        stop_btn,
  input  logic        shift_tick,
  output logic [63:0] matrix,
  output logic [2:0]  row_idx,
  output logic        playing,
  output logic        win,
  output logic        lose
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WIN, S_LOSE} state_t;

  localparam logic [7:0] INIT_MASK    = 8'((32'd1 << START_WIDTH) - 32'd1);
  localparam logic [3:0] HOLDOFF_INIT = 4'(HOLDOFF_TICKS);
  localparam logic       DIR_LEFT     = 1'b0;
  localparam logic       DIR_RIGHT    = 1'b1;

  state_t      state_q, state_d;
  logic [7:0]  rows_q [8];
  logic [7:0]  rows_d [8];
  logic [7:0]  mask_q, mask_d;
  logic        dir_q, dir_d;
  logic [2:0]  row_idx_q, row_idx_d;
  logic [3:0]  holdoff_q, holdoff_d;
  logic        sync1_q, sync2_q, sync3_q;
  logic [63:0] matrix_q, matrix_d;
  logic        playing_q, playing_d;
  logic        win_q, win_d;
  logic        lose_q, lose_d;

  logic        stop_pulse;
  logic [7:0]  below;
  logic [7:0]  locked;

  assign stop_pulse = sync2_q & ~sync3_q;
  assign below      = rows_q[3'(row_idx_q - 3'd1)];
  assign locked     = (row_idx_q == 3'd0) ? mask_q : (mask_q & below);

  always_comb begin
    state_d   = state_q;
    rows_d    = rows_q;
    mask_d    = mask_q;
    dir_d     = dir_q;
    row_idx_d = row_idx_q;
    holdoff_d = holdoff_q;

    if (!start_sw || state_q == S_IDLE) begin
      // Leaving a game and starting one both begin from a clean board.
      state_d   = start_sw ? S_RUN : S_IDLE;
      rows_d    = '{default: 8'h00};
      mask_d    = INIT_MASK;
      dir_d     = DIR_LEFT;
      row_idx_d = 3'd0;
      holdoff_d = 4'd0;
    end else if (state_q == S_RUN) begin
      if (stop_pulse && holdoff_q == 4'd0) begin
        if (locked == 8'h00) begin
          rows_d[row_idx_q] = mask_q;
          state_d           = S_LOSE;
        end else begin
          rows_d[row_idx_q] = locked;
          if (row_idx_q == 3'd7) begin
            state_d = S_WIN;
          end else begin
            row_idx_d = row_idx_q + 3'd1;
            mask_d    = locked;
            holdoff_d = HOLDOFF_INIT;
          end
        end
      end else if (shift_tick) begin
        if (holdoff_q != 4'd0) holdoff_d = holdoff_q - 4'd1;
        // A full-width block has nowhere to move without losing bits.
        if (mask_q[7] && mask_q[0]) begin
          mask_d = mask_q;
        end else if (dir_q == DIR_LEFT && mask_q[7]) begin
          dir_d  = DIR_RIGHT;
          mask_d = mask_q >> 1;
        end else if (dir_q == DIR_RIGHT && mask_q[0]) begin
          dir_d  = DIR_LEFT;
          mask_d = mask_q << 1;
        end else if (dir_q == DIR_LEFT) begin
          mask_d = mask_q << 1;
        end else begin
          mask_d = mask_q >> 1;
        end
      end
    end
  end

  always_comb begin
    matrix_d  = 64'h0;
    playing_d = (state_d == S_RUN);
    win_d     = (state_d == S_WIN);
    lose_d    = (state_d == S_LOSE);
    for (int r = 0; r < 8; r++) begin
      if (state_d != S_RUN)           matrix_d[63-8*r -: 8] = rows_d[r];
      else if (3'(r) < row_idx_d)     matrix_d[63-8*r -: 8] = rows_d[r];
      else if (3'(r) == row_idx_d)    matrix_d[63-8*r -: 8] = mask_d;
      else                            matrix_d[63-8*r -: 8] = 8'h00;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rows_q    <= '{default: 8'h00};
      mask_q    <= INIT_MASK;
      dir_q     <= DIR_LEFT;
      row_idx_q <= 3'd0;
      holdoff_q <= 4'd0;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      sync3_q   <= 1'b0;
      matrix_q  <= 64'h0;
      playing_q <= 1'b0;
      win_q     <= 1'b0;
      lose_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rows_q    <= rows_d;
      mask_q    <= mask_d;
      dir_q     <= dir_d;
      row_idx_q <= row_idx_d;
      holdoff_q <= holdoff_d;
      sync1_q   <= stop_btn;
      sync2_q   <= sync1_q;
      sync3_q   <= sync2_q;
      matrix_q  <= matrix_d;
      playing_q <= playing_d;
      win_q     <= win_d;
      lose_q    <= lose_d;
    end
  end

  assign matrix  = matrix_q;
  assign row_idx = row_idx_q;
  assign playing = playing_q;
  assign win     = win_q;
  assign lose    = lose_q;

endmodule

// File: tb/tb_stack_game_sequencer.sv
// Bench for stack_game_sequencer: vector table plus hand-built win, hold and reset sequences.
module tb_stack_game_sequencer;

  logic        clk;
  logic        rst;
  logic        start_sw;
  logic        stop_btn;
  logic        shift_tick;
  logic [63:0] matrix;
  logic [2:0]  row_idx;
  logic        playing;
  logic        win;
  logic        lose;

  stack_game_sequencer #(.START_WIDTH(3), .HOLDOFF_TICKS(2)) dut (
    .clk(clk), .rst(rst), .start_sw(start_sw), .stop_btn(stop_btn),
    .shift_tick(shift_tick), .matrix(matrix), .row_idx(row_idx),
    .playing(playing), .win(win), .lose(lose)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] mat;
    logic [2:0]  row;
    logic        p, w, l;
    string       name;
  } exp_t;

  typedef struct {
    logic        st, sp, tk;
    logic [63:0] mat;
    logic [2:0]  row;
    logic        p, w, l;
  } vec_t;

  exp_t exp_q[$];
  vec_t vtab[$];
  int   vectors;
  int   miscompares;

  function automatic logic [63:0] mat(input logic [7:0] a, b, c, d, e, f, g, h);
    return {a, b, c, d, e, f, g, h};
  endfunction

  task automatic add(input logic st, sp, tk, input logic [63:0] m, input logic [2:0] r,
                     input logic p, w, l);
    vec_t v;
    v.st = st; v.sp = sp; v.tk = tk; v.mat = m; v.row = r; v.p = p; v.w = w; v.l = l;
    vtab.push_back(v);
  endtask

  task automatic push(input logic [63:0] m, input logic [2:0] r, input logic p, w, l,
                      input string name);
    exp_t e;
    e.mat = m; e.row = r; e.p = p; e.w = w; e.l = l; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty: no expected entry queued");
    end else begin
      e = exp_q.pop_front();
      if (matrix !== e.mat || row_idx !== e.row || playing !== e.p || win !== e.w || lose !== e.l) begin
        miscompares++;
        $display("FAIL %s: got matrix=%h row=%0d pwl=%b%b%b, expected matrix=%h row=%0d pwl=%b%b%b",
                 e.name, matrix, row_idx, playing, win, lose, e.mat, e.row, e.p, e.w, e.l);
      end
    end
  endtask

  task automatic cyc(input logic st, sp, tk);
    start_sw = st; stop_btn = sp; shift_tick = tk;
    @(posedge clk);
    #1;
  endtask

  task automatic press_lock();
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
  endtask

  task automatic release_btn();
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b1);
  endtask

  function automatic logic [63:0] stack07(input int nbytes);
    logic [63:0] m;
    m = 64'h0;
    for (int k = 0; k < nbytes && k < 8; k++) m[63-8*k -: 8] = 8'h07;
    return m;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1; start_sw = 1'b1; stop_btn = 1'b0; shift_tick = 1'b0;

    // Bounce, lock, holdoff, partial overlap, collision, miss and freeze.
    add(0,0,0, 64'h0,                                   0, 0,0,0);
    add(1,0,0, mat(8'h07,0,0,0,0,0,0,0),                0, 1,0,0);
    add(1,0,1, mat(8'h0E,0,0,0,0,0,0,0),                0, 1,0,0);
    add(1,0,1, mat(8'h1C,0,0,0,0,0,0,0),                0, 1,0,0);
    add(1,0,1, mat(8'h38,0,0,0,0,0,0,0),                0, 1,0,0);
    add(1,0,1, mat(8'h70,0,0,0,0,0,0,0),                0, 1,0,0);
    add(1,0,1, mat(8'hE0,0,0,0,0,0,0,0),                0, 1,0,0);
    add(1,0,1, mat(8'h70,0,0,0,0,0,0,0),                0, 1,0,0);
    add(1,0,1, mat(8'h38,0,0,0,0,0,0,0),                0, 1,0,0);
    add(1,0,1, mat(8'h1C,0,0,0,0,0,0,0),                0, 1,0,0);
    add(1,0,1, mat(8'h0E,0,0,0,0,0,0,0),                0, 1,0,0);
    add(1,0,1, mat(8'h07,0,0,0,0,0,0,0),                0, 1,0,0);
    add(1,0,1, mat(8'h0E,0,0,0,0,0,0,0),                0, 1,0,0);
    add(1,0,1, mat(8'h1C,0,0,0,0,0,0,0),                0, 1,0,0);
    add(1,1,0, mat(8'h1C,0,0,0,0,0,0,0),                0, 1,0,0);
    add(1,1,0, mat(8'h1C,0,0,0,0,0,0,0),                0, 1,0,0);
    add(1,1,0, mat(8'h1C,8'h1C,0,0,0,0,0,0),            1, 1,0,0);
    add(1,0,0, mat(8'h1C,8'h1C,0,0,0,0,0,0),            1, 1,0,0);
    add(1,0,1, mat(8'h1C,8'h38,0,0,0,0,0,0),            1, 1,0,0);
    add(1,1,0, mat(8'h1C,8'h38,0,0,0,0,0,0),            1, 1,0,0);
    add(1,1,0, mat(8'h1C,8'h38,0,0,0,0,0,0),            1, 1,0,0);
    add(1,1,0, mat(8'h1C,8'h38,0,0,0,0,0,0),            1, 1,0,0);
    add(1,0,0, mat(8'h1C,8'h38,0,0,0,0,0,0),            1, 1,0,0);
    add(1,0,1, mat(8'h1C,8'h70,0,0,0,0,0,0),            1, 1,0,0);
    add(1,0,1, mat(8'h1C,8'hE0,0,0,0,0,0,0),            1, 1,0,0);
    add(1,0,1, mat(8'h1C,8'h70,0,0,0,0,0,0),            1, 1,0,0);
    add(1,0,1, mat(8'h1C,8'h38,0,0,0,0,0,0),            1, 1,0,0);
    add(1,1,0, mat(8'h1C,8'h38,0,0,0,0,0,0),            1, 1,0,0);
    add(1,1,0, mat(8'h1C,8'h38,0,0,0,0,0,0),            1, 1,0,0);
    add(1,1,0, mat(8'h1C,8'h18,8'h18,0,0,0,0,0),        2, 1,0,0);
    add(1,0,0, mat(8'h1C,8'h18,8'h18,0,0,0,0,0),        2, 1,0,0);
    add(1,0,1, mat(8'h1C,8'h18,8'h0C,0,0,0,0,0),        2, 1,0,0);
    add(1,0,1, mat(8'h1C,8'h18,8'h06,0,0,0,0,0),        2, 1,0,0);
    add(1,0,1, mat(8'h1C,8'h18,8'h03,0,0,0,0,0),        2, 1,0,0);
    add(1,0,1, mat(8'h1C,8'h18,8'h06,0,0,0,0,0),        2, 1,0,0);
    add(1,0,1, mat(8'h1C,8'h18,8'h0C,0,0,0,0,0),        2, 1,0,0);
    add(1,1,0, mat(8'h1C,8'h18,8'h0C,0,0,0,0,0),        2, 1,0,0);
    add(1,1,0, mat(8'h1C,8'h18,8'h0C,0,0,0,0,0),        2, 1,0,0);
    add(1,1,1, mat(8'h1C,8'h18,8'h08,8'h08,0,0,0,0),    3, 1,0,0);
    add(1,0,0, mat(8'h1C,8'h18,8'h08,8'h08,0,0,0,0),    3, 1,0,0);
    add(1,0,1, mat(8'h1C,8'h18,8'h08,8'h10,0,0,0,0),    3, 1,0,0);
    add(1,0,1, mat(8'h1C,8'h18,8'h08,8'h20,0,0,0,0),    3, 1,0,0);
    add(1,1,0, mat(8'h1C,8'h18,8'h08,8'h20,0,0,0,0),    3, 1,0,0);
    add(1,1,0, mat(8'h1C,8'h18,8'h08,8'h20,0,0,0,0),    3, 1,0,0);
    add(1,1,0, mat(8'h1C,8'h18,8'h08,8'h20,0,0,0,0),    3, 0,0,1);
    add(1,0,1, mat(8'h1C,8'h18,8'h08,8'h20,0,0,0,0),    3, 0,0,1);
    add(1,1,1, mat(8'h1C,8'h18,8'h08,8'h20,0,0,0,0),    3, 0,0,1);
    add(1,1,0, mat(8'h1C,8'h18,8'h08,8'h20,0,0,0,0),    3, 0,0,1);
    add(1,1,1, mat(8'h1C,8'h18,8'h08,8'h20,0,0,0,0),    3, 0,0,1);
    add(1,0,0, mat(8'h1C,8'h18,8'h08,8'h20,0,0,0,0),    3, 0,0,1);
    add(0,0,0, 64'h0,                                   0, 0,0,0);

    #2;
    push(64'h0, 0, 0, 0, 0, "reset_async");
    pop_check();
    @(posedge clk); #1;
    @(posedge clk); #1;
    push(64'h0, 0, 0, 0, 0, "reset_hold");
    pop_check();
    start_sw = 1'b0;
    rst = 1'b0;

    foreach (vtab[i]) begin
      push(vtab[i].mat, vtab[i].row, vtab[i].p, vtab[i].w, vtab[i].l, $sformatf("vec%0d", i));
      cyc(vtab[i].st, vtab[i].sp, vtab[i].tk);
      pop_check();
    end

    // Win run; the first lock is made with the button held for 100 cycles.
    push(stack07(1), 0, 1, 0, 0, "win_start");
    cyc(1'b1, 1'b0, 1'b0);
    pop_check();
    push(stack07(2), 1, 1, 0, 0, "hold_first_lock");
    press_lock();
    pop_check();
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 87; i++) cyc(1'b1, 1'b1, 1'b0);
    push(stack07(2), 1, 1, 0, 0, "hold_single_lock");
    pop_check();
    release_btn();
    for (int r = 1; r < 8; r++) begin
      if (r < 7) push(stack07(r + 2), 3'(r + 1), 1, 0, 0, $sformatf("win_lock%0d", r));
      else       push(stack07(8), 3'd7, 0, 1, 0, "win_final");
      press_lock();
      pop_check();
      release_btn();
      if (r < 7) ticks(10);
    end
    press_lock();
    ticks(4);
    push(stack07(8), 3'd7, 0, 1, 0, "win_frozen");
    pop_check();
    push(64'h0, 0, 0, 0, 0, "win_to_idle");
    cyc(1'b0, 1'b0, 1'b0);
    pop_check();

    // Asynchronous reset in the middle of a game with row 3 active.
    cyc(1'b1, 1'b0, 1'b0);
    for (int r = 0; r < 3; r++) begin
      press_lock();
      release_btn();
      ticks(10);
    end
    push(stack07(4), 3, 1, 0, 0, "pre_reset_row3");
    pop_check();
    #2 rst = 1'b1;
    #1;
    push(64'h0, 0, 0, 0, 0, "rst_mid_run");
    pop_check();
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    push(64'h0, 0, 0, 0, 0, "rst_held");
    pop_check();
    rst = 1'b0;
    push(mat(8'h07,0,0,0,0,0,0,0), 0, 1, 0, 0, "rst_release_run");
    cyc(1'b1, 1'b0, 1'b0);
    pop_check();
    push(mat(8'h0E,0,0,0,0,0,0,0), 0, 1, 0, 0, "rst_dir_left");
    cyc(1'b1, 1'b0, 1'b1);
    pop_check();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
